// File: rtl/interrupt_controller.sv
// Interrupt arbiter: edge-latched IF/IE registers, fixed priority (bit0 highest), CPU irq/vector handshake.
// Latency: IF sets 1 cycle after a src_req rising edge, cpu_irq 1 cycle after pending; bus reads 1 cycle.
// No backpressure: a presented request holds until cpu_ack or cancel. INTC_WAKE_EN adds the wake output.
module interrupt_controller #(
   parameter logic [15:0] IF_ADDR       = 16'hFF0F,
   parameter logic [15:0] IE_ADDR       = 16'hFFFF,
   parameter logic [7:0]  VECTOR_BASE   = 8'h40,
   parameter int unsigned VECTOR_STRIDE = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [4:0]  src_req,
   output logic [4:0]  src_ack,
   output logic        cpu_irq,
   output logic [7:0]  cpu_vector,
   input  logic        cpu_ack,
   input  logic [15:0] A,
   input  logic [7:0]  Di,
   output logic [7:0]  Do,
   input  logic        wr_n,
   input  logic        rd_n,
   input  logic        cs
`ifdef INTC_WAKE_EN
   ,
   output logic        wake
`endif
);

   typedef enum logic [1:0] {IDLE, PRESENT, DONE} state_t;

   state_t      state;
   logic [4:0]  if_reg;
   logic [4:0]  ie_reg;
   logic [4:0]  req_prev;
   logic [4:0]  rise;
   logic [4:0]  pending;
   logic [4:0]  win_mask;
   logic [4:0]  cur_mask;
   logic [4:0]  ack_clr;
   logic [4:0]  if_wr_val;
   logic [2:0]  win_idx;
   logic [7:0]  rd_latch;
   logic        bus_wr;
   logic        bus_rd;
   logic        cur_live;
   logic        unused_di;

   assign bus_wr    = cs & ~wr_n;
   assign bus_rd    = cs & wr_n & ~rd_n;
   assign rise      = src_req & ~req_prev;
   assign pending   = if_reg & ie_reg;
   assign win_mask  = pending & (~pending + 5'd1);
   assign cur_live  = |(if_reg & ie_reg & cur_mask);
   assign ack_clr   = (state == PRESENT && cur_live && cpu_ack) ? cur_mask : 5'b0;
   assign if_wr_val = (bus_wr && A == IF_ADDR) ? Di[4:0] : if_reg;
   assign unused_di = ^Di[7:5];
   assign Do        = cs ? rd_latch : 8'hzz;

`ifdef INTC_WAKE_EN
   assign wake = |pending;
`endif

   always_comb begin
      win_idx = 3'd0;
      for (int i = 4; i >= 0; i--) begin
         if (pending[i]) win_idx = 3'(i);
      end
   end

   // Layered so a source edge beats an ack clear, which beats a bus write.
   always_ff @(posedge clock) begin
      if (reset) begin
         if_reg   <= 5'b0;
         ie_reg   <= 5'b0;
         req_prev <= 5'b0;
      end else begin
         if_reg   <= (if_wr_val & ~ack_clr) | rise;
         req_prev <= src_req;
         if (bus_wr && A == IE_ADDR) ie_reg <= Di[4:0];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rd_latch <= 8'h00;
      end else if (bus_rd) begin
         if (A == IF_ADDR)      rd_latch <= {3'b111, if_reg};
         else if (A == IE_ADDR) rd_latch <= {3'b000, ie_reg};
         else                   rd_latch <= 8'hFF;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cpu_irq    <= 1'b0;
         cpu_vector <= 8'h00;
         src_ack    <= 5'b0;
         cur_mask   <= 5'b0;
      end else begin
         src_ack <= 5'b0;
         case (state)
            IDLE: begin
               if (|pending) begin
                  cur_mask   <= win_mask;
                  cpu_vector <= VECTOR_BASE + 8'(VECTOR_STRIDE) * {5'b0, win_idx};
                  cpu_irq    <= 1'b1;
                  state      <= PRESENT;
               end
            end
            PRESENT: begin
               // Source withdrawn (IF or IE cleared) cancels without an ack.
               if (!cur_live) begin
                  cpu_irq <= 1'b0;
                  state   <= IDLE;
               end else if (cpu_ack) begin
                  src_ack <= cur_mask;
                  cpu_irq <= 1'b0;
                  state   <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with an expected-value queue and immediate assertions.
module tb_interrupt_controller;

   localparam logic [15:0] IF_A = 16'hFF0F;
   localparam logic [15:0] IE_A = 16'hFFFF;

   logic        clock = 1'b0;
   logic        reset;
   logic [4:0]  src_req;
   logic [4:0]  src_ack;
   logic        cpu_irq;
   logic [7:0]  cpu_vector;
   logic        cpu_ack;
   logic [15:0] A;
   logic [7:0]  Di;
   wire  [7:0]  Do;
   logic        wr_n;
   logic        rd_n;
   logic        cs;

   int          n_cmp  = 0;
   int          n_fail = 0;
   logic [7:0]  exp_q[$];
   string       tag_q[$];
   logic [7:0]  rd_d;

   interrupt_controller dut (
      .clock      (clock),
      .reset      (reset),
      .src_req    (src_req),
      .src_ack    (src_ack),
      .cpu_irq    (cpu_irq),
      .cpu_vector (cpu_vector),
      .cpu_ack    (cpu_ack),
      .A          (A),
      .Di         (Di),
      .Do         (Do),
      .wr_n       (wr_n),
      .rd_n       (rd_n),
      .cs         (cs)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic push(input string t, input logic [7:0] e);
      tag_q.push_back(t);
      exp_q.push_back(e);
   endtask

   task automatic check(input logic [7:0] obs);
      string      t;
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         n_fail++;
         $error("FAIL scoreboard_empty: observed %02h expected none", obs);
      end else begin
         t = tag_q.pop_front();
         e = exp_q.pop_front();
         n_cmp++;
         assert (obs === e) else begin
            n_fail++;
            $error("FAIL %s: observed %02h expected %02h", t, obs, e);
         end
      end
   endtask

   task automatic chk_irq(input string t, input logic e);
      push(t, {7'b0, e});
      check({7'b0, cpu_irq});
   endtask

   task automatic chk_vec(input string t, input logic [7:0] e);
      push(t, e);
      check(cpu_vector);
   endtask

   task automatic chk_ack(input string t, input logic [4:0] e);
      push(t, {3'b0, e});
      check({3'b0, src_ack});
   endtask

   task automatic bus_write(input logic [15:0] addr, input logic [7:0] d);
      A = addr; Di = d; cs = 1'b1; wr_n = 1'b0;
      tick();
      cs = 1'b0; wr_n = 1'b1;
   endtask

   task automatic rd_chk(input logic [15:0] addr, input string t, input logic [7:0] e);
      push(t, e);
      A = addr; cs = 1'b1; rd_n = 1'b0;
      tick();
      rd_d = Do;
      cs = 1'b0; rd_n = 1'b1;
      check(rd_d);
   endtask

   task automatic pulse_ack();
      cpu_ack = 1'b1;
      tick();
      cpu_ack = 1'b0;
   endtask

   initial begin
      reset = 1'b1; src_req = 5'b0; cpu_ack = 1'b0;
      A = 16'h0; Di = 8'h0; wr_n = 1'b1; rd_n = 1'b1; cs = 1'b0;
      tick(); tick();
      chk_irq("rst_irq", 1'b0);
      chk_ack("rst_ack", 5'b0);
      chk_vec("rst_vec", 8'h00);
      reset = 1'b0;
      rd_chk(IF_A, "rst_if", 8'hE0);
      rd_chk(IE_A, "rst_ie", 8'h00);

      // Timer request, full handshake
      bus_write(IE_A, 8'h04);
      src_req[2] = 1'b1;
      tick();
      chk_irq("tmr_irq_lat", 1'b0);
      tick();
      chk_irq("tmr_irq", 1'b1);
      chk_vec("tmr_vec", 8'h50);
      rd_chk(IF_A, "tmr_if_set", 8'hE4);
      pulse_ack();
      chk_ack("tmr_src_ack", 5'b00100);
      chk_irq("tmr_irq_drop", 1'b0);
      tick();
      chk_ack("tmr_ack_1cyc", 5'b0);
      rd_chk(IF_A, "tmr_if_clr", 8'hE0);

      // Held level does not re-set IF; a new edge does
      tick(); tick();
      chk_irq("hold_no_reset", 1'b0);
      rd_chk(IF_A, "hold_if", 8'hE0);
      src_req[2] = 1'b0;
      tick();
      src_req[2] = 1'b1;
      tick(); tick();
      chk_irq("reedge_irq", 1'b1);
      rd_chk(IF_A, "reedge_if", 8'hE4);
      pulse_ack();
      chk_ack("reedge_ack", 5'b00100);
      tick();
      src_req[2] = 1'b0;
      tick();

      // cpu_ack while idle is ignored
      bus_write(IE_A, 8'h00);
      src_req[2] = 1'b1;
      tick();
      pulse_ack();
      chk_ack("idle_ack_ign", 5'b0);
      chk_irq("idle_irq", 1'b0);
      rd_chk(IF_A, "idle_if_kept", 8'hE4);
      bus_write(IF_A, 8'h00);
      src_req[2] = 1'b0;

      // Simultaneous VBlank and Joypad
      bus_write(IE_A, 8'h1F);
      src_req = 5'b10001;
      tick(); tick();
      chk_irq("pri_irq", 1'b1);
      chk_vec("pri_vec_vbl", 8'h40);
      pulse_ack();
      chk_ack("pri_ack_vbl", 5'b00001);
      tick();
      chk_irq("pri_done_gap", 1'b0);
      tick();
      chk_irq("pri_irq2", 1'b1);
      chk_vec("pri_vec_joy", 8'h60);
      rd_chk(IF_A, "pri_if_joy", 8'hF0);
      pulse_ack();
      chk_ack("pri_ack_joy", 5'b10000);
      tick(); tick();
      src_req = 5'b0;
      tick();

      // Higher priority arrival does not preempt
      src_req[3] = 1'b1;
      tick(); tick();
      chk_vec("nopre_vec", 8'h58);
      src_req[0] = 1'b1;
      tick(); tick(); tick();
      chk_vec("nopre_held", 8'h58);
      chk_irq("nopre_irq", 1'b1);
      pulse_ack();
      chk_ack("nopre_ack", 5'b01000);
      tick(); tick();
      chk_vec("nopre_next", 8'h40);
      pulse_ack();
      chk_ack("nopre_ack0", 5'b00001);
      tick(); tick();
      src_req = 5'b0;
      tick();

      // Cancel by clearing IE during PRESENT
      bus_write(IE_A, 8'h04);
      src_req[2] = 1'b1;
      tick(); tick();
      chk_irq("cxl_irq", 1'b1);
      chk_vec("cxl_vec", 8'h50);
      bus_write(IE_A, 8'h00);
      tick();
      chk_irq("cxl_drop", 1'b0);
      chk_ack("cxl_no_ack", 5'b0);
      tick();
      chk_ack("cxl_no_ack2", 5'b0);
      chk_vec("cxl_vec_hold", 8'h50);
      rd_chk(IF_A, "cxl_if_kept", 8'hE4);
      bus_write(IF_A, 8'h00);
      src_req = 5'b0;
      tick();

      // Edge set beats a same-cycle IF write
      bus_write(IF_A, 8'h1D);
      rd_chk(IF_A, "ifwr_val", 8'hFD);
      A = IF_A; Di = 8'h00; cs = 1'b1; wr_n = 1'b0; src_req[1] = 1'b1;
      tick();
      cs = 1'b0; wr_n = 1'b1;
      rd_chk(IF_A, "edge_wins", 8'hE2);

      // Reset while presenting
      bus_write(IE_A, 8'h02);
      tick();
      chk_irq("prerst_irq", 1'b1);
      chk_vec("prerst_vec", 8'h48);
      reset = 1'b1; src_req = 5'b0;
      tick();
      chk_irq("midrst_irq", 1'b0);
      chk_vec("midrst_vec", 8'h00);
      chk_ack("midrst_ack", 5'b0);
      reset = 1'b0;
      rd_chk(IF_A, "midrst_if", 8'hE0);
      rd_chk(IE_A, "midrst_ie", 8'h00);

      if (exp_q.size() != 0) begin
         n_fail++;
         $error("FAIL scoreboard_leftover: observed %0d expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Central interrupt arbiter for the GB core. It owns the IF (FF0F) and IE (FFFF) registers and edge-latches requests from five sources: VBlank, LCD STAT, Timer, Serial and Joypad. It selects the highest-priority enabled pending source, presents an irq and vector to the CPU, and on CPU acceptance clears the IF bit and returns a one-cycle int_ack pulse to the serviced source (e.g. the timer's int_ack input).

Parameters:
IF_ADDR, 16'hFF0F, bus address of IF register
IE_ADDR, 16'hFFFF, bus address of IE register
VECTOR_BASE, 8'h40, vector of source 0
VECTOR_STRIDE, 8, vector spacing between sources

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
src_req  in  5  level requests from sources; bit0 VBlank, 1 STAT, 2 Timer, 3 Serial, 4 Joypad
src_ack  out  5  one-cycle ack pulse to serviced source
cpu_irq  out  1  interrupt request to CPU
cpu_vector  out  8  vector of the request being presented
cpu_ack  in  1  CPU accepts presented interrupt (single-cycle pulse)
A  in  16  bus address
Di  in  8  bus write data
Do  out  8  bus read data; 8'hZZ when cs low
wr_n  in  1  write strobe, active-low
rd_n  in  1  read strobe, active-low
cs  in  1  chip select

Behaviour:
- Reset: Interface: reset reset, synchronous, active-high; clock clock. On reset: IF=0, IE=0, src_req history=0, src_ack=0, cpu_irq=0, cpu_vector=8'h00, read latch=0, state=IDLE.
- Edge detect: per bit, a rising edge of src_req (registered previous value) sets IF[n] in the following cycle. A held level does not re-set IF after it is cleared.
- Bus write, when cs and !wr_n: IF_ADDR loads IF<=Di[4:0]; IE_ADDR loads IE<=Di[4:0]. Other addresses are ignored.
- Bus read, when cs, wr_n high and !rd_n: registered into the read latch. IF reads as {3'b111,IF}; IE reads as {3'b000,IE}. Do = cs ? latch : 8'hZZ.
- Simultaneous events on one IF bit in the same cycle: precedence is edge-set > cpu_ack-clear > bus write.
- pending = IF & IE. Winner = lowest set bit of pending (bit0 highest priority).
- FSM IDLE: if pending != 0, latch winner index; cpu_vector <= VECTOR_BASE + VECTOR_STRIDE*idx; cpu_irq <= 1; go to PRESENT. Latency is 1 cycle from pending becoming nonzero to cpu_irq high.
- FSM PRESENT: the latched index is frozen. A higher-priority arrival does not preempt.
  - On cpu_ack: clear IF[idx], pulse src_ack[idx] for exactly 1 cycle, cpu_irq <= 0, go to DONE.
  - If IF[idx] or IE[idx] drops to 0 before cpu_ack: cpu_irq <= 0, no src_ack, go to IDLE (cancel).
- FSM DONE: one idle cycle so the next arbitration sees the updated IF, then IDLE.
- cpu_ack while in IDLE or DONE is ignored.
- cpu_vector holds its last value while cpu_irq is low.
- Reset asserted in any state returns to IDLE immediately with all outputs at reset values. No src_ack is emitted.

Optional Feature:
INTC_WAKE_EN. When defined, adds output port wake (1 bit) = |(IF & IE), combinational and state-independent, so a halted CPU can resume even with IME clear. When undefined, the port does not exist and behaviour is otherwise identical.

Test Plan:
- Reset, then read FF0F and FFFF -> Do=8'hE0 and 8'h00; cpu_irq=0, src_ack=0.
- IE=8'h04, pulse src_req[2] -> IF=8'hE4; cpu_irq high 1 cycle after IF sets; vector=8'h50. Pulse cpu_ack -> src_ack=5'b00100 for 1 cycle, IF reads 8'hE0.
- IE=8'h1F, src_req[4] and src_req[0] rise in the same cycle -> vector 8'h40 first. After ack and the DONE cycle -> vector 8'h60.
- In PRESENT with vector 8'h50, write IE=0 -> cpu_irq drops the next cycle, no src_ack, IF[2] remains 1.
- Hold src_req[2] high across cpu_ack -> IF[2] is not re-set. Lower then raise it -> IF[2] sets again.
- Bus write of IF=0 in the same cycle as a src_req[1] rising edge -> IF[1]=1 (edge set wins).
